unpad_crop: RTL and testbench
=============================

UNPAD_CROP -- requirements
Module: unpad_crop

Interface
REQ-001 Parameter SIZE, default 5, cropped output matrix dimension (SIZE >= 2).
REQ-002 Parameter DW, default 32, element width in bits.
REQ-003 Parameter ROW_OFF, default 0, first kept row of the padded frame; ROW_OFF+SIZE <= 2*SIZE-1.
REQ-004 Parameter COL_OFF, default 0, first kept column of the padded frame; COL_OFF+SIZE <= 2*SIZE-1.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_data  input  DW  padded-frame element, row-major, PSIZE=2*SIZE-1 per row.
REQ-008 in_valid  input  1  in_data valid.
REQ-009 in_last  input  1  marks the final element of a padded frame.
REQ-010 in_ready  output  1  block accepts the input element this cycle.
REQ-011 out_data  output  DW  kept (cropped) element, row-major.
REQ-012 out_valid  output  1  out_data valid.
REQ-013 out_last  output  1  marks the final element of the cropped SIZE x SIZE frame.
REQ-014 out_ready  input  1  downstream accepts out_data.
REQ-015 frame_err  output  1  one-cycle pulse on a padded-frame length violation.

Function
REQ-016 Input transfer on in_valid && in_ready; output transfer on out_valid && out_ready.
REQ-017 in_ready = !out_valid || out_ready, combinational, for every element, kept or dropped.
REQ-018 Row counter r and column counter c (0..PSIZE-1) track the position of the next input element; c advances per input transfer, wraps to 0 at PSIZE-1 and increments r.
REQ-019 An element is kept iff ROW_OFF <= r < ROW_OFF+SIZE and COL_OFF <= c < COL_OFF+SIZE; otherwise it is dropped with no output.
REQ-020 A kept element appears on out_data with out_valid high on the cycle after its input transfer (latency 1).
REQ-021 out_last = 1 exactly with the kept element at r=ROW_OFF+SIZE-1, c=COL_OFF+SIZE-1.
REQ-022 out_valid, out_data, out_last hold stable while out_valid && !out_ready.
REQ-023 A dropped element transfer with no output transfer leaves out_valid unchanged.
REQ-024 Simultaneous output transfer and kept-input transfer: output register reloads, out_valid stays 1, no bubble.
REQ-025 Normal frame end: in_last at r=c=PSIZE-1; counters return to 0.
REQ-026 Early last: in_last before r=c=PSIZE-1 -> frame_err pulses the next cycle, counters return to 0; a kept element in that transfer is still output; out_last is not generated for that frame.
REQ-027 Missing last: r=c=PSIZE-1 transferred without in_last -> frame_err pulses the next cycle, counters wrap to 0.
REQ-028 Counters use ceil(log2(PSIZE)) bits; no arithmetic wider than counter width plus one.

Reset
REQ-029 On reset: out_valid=0, out_last=0, out_data=0, frame_err=0, r=0, c=0.
REQ-030 Reset mid-frame discards the partial frame and any pending output; the first transfer after reset deasserts is element (0,0) of a new frame.
REQ-031 in_ready is 1 during the cycle after reset.

Structure
REQ-032 Shared package pad_pkg holds DW_DEFAULT=32, SIZE_DEFAULT=5 and function psize(size)=2*size-1, also used by zero_pad.
REQ-033 One sub-module stream_reg: single-entry valid/ready output register carrying {data,last}.

Verification (SIZE=5, PSIZE=9, in_data = flat index 0..80, in_last on index 80)
REQ-034 Offsets 0, out_ready=1, in_valid=1 -> outputs 0,1,2,3,4,9,...,36..40 (25 words), out_last only on 40, no frame_err.
REQ-035 ROW_OFF=2, COL_OFF=3 -> first output 21, last output 61 with out_last, 25 words.
REQ-036 out_ready random 50% -> same 25-word sequence, no loss or duplicate, outputs stable while stalled.
REQ-037 in_last on index 50 -> frame_err one cycle; next 81-word frame yields correct 25 words with out_last.
REQ-038 Index 80 sent without in_last -> frame_err one cycle; next frame starts at (0,0).
REQ-039 reset asserted after index 30 -> out_valid=0 next cycle; fresh frame yields 0..40 sequence correctly.

Source files
------------

// File: rtl/pad_pkg.sv
// Shared sizing constants and helpers for the padding / unpadding blocks.
package pad_pkg;

    localparam int DW_DEFAULT   = 32;
    localparam int SIZE_DEFAULT = 5;

    // Side length of a padded frame built from a SIZE x SIZE matrix.
    function automatic int psize(input int size);
        return 2 * size - 1;
    endfunction

endpackage

// File: rtl/unpad_crop_stream_reg.sv
// Single-entry valid/ready output register; payload is opaque to this block.
module stream_reg #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         accept_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    // A load always wins over a drain so back-to-back transfers leave no bubble.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o  = valid_q;
    assign data_o   = data_q;
    assign accept_o = !valid_q || ready_i;

endmodule

// File: rtl/unpad_crop.sv
// Crops a SIZE x SIZE window out of a row-major (2*SIZE-1)^2 padded stream,
// flagging frames whose in_last does not line up with the final element.
module unpad_crop
    import pad_pkg::*;
#(
    parameter int SIZE    = SIZE_DEFAULT,
    parameter int DW      = DW_DEFAULT,
    parameter int ROW_OFF = 0,
    parameter int COL_OFF = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    input  logic          in_last,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          out_last,
    input  logic          out_ready,
    output logic          frame_err
);

    localparam int PSIZE = psize(SIZE);
    localparam int CW    = $clog2(PSIZE);

    localparam logic [CW-1:0] PMAX     = CW'(PSIZE - 1);
    localparam logic [CW-1:0] ROW_LAST = CW'(ROW_OFF + SIZE - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COL_OFF + SIZE - 1);
    localparam logic [CW:0]   ROW_LO   = (CW+1)'(ROW_OFF);
    localparam logic [CW:0]   COL_LO   = (CW+1)'(COL_OFF);
    localparam logic [CW:0]   SIZE_W   = (CW+1)'(SIZE);

    logic [CW-1:0] r_q, r_d, c_q, c_d;
    logic          frame_err_q, frame_err_d;
    logic [CW:0]   row_rel, col_rel;
    logic          kept, kept_last, xfer, at_end;
    logic [DW:0]   out_payload;

    // Offsetting wraps positions before the window to a value above SIZE,
    // so one unsigned compare per axis covers both bounds.
    assign row_rel   = {1'b0, r_q} - ROW_LO;
    assign col_rel   = {1'b0, c_q} - COL_LO;
    assign kept      = (row_rel < SIZE_W) && (col_rel < SIZE_W);
    assign kept_last = (r_q == ROW_LAST) && (c_q == COL_LAST);
    assign xfer      = in_valid && in_ready;
    assign at_end    = (r_q == PMAX) && (c_q == PMAX);

    always_comb begin
        r_d         = r_q;
        c_d         = c_q;
        frame_err_d = 1'b0;
        if (xfer) begin
            if (in_last || at_end) begin
                r_d         = '0;
                c_d         = '0;
                frame_err_d = in_last ^ at_end;
            end else if (c_q == PMAX) begin
                c_d = '0;
                r_d = r_q + CW'(1);
            end else begin
                c_d = c_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q         <= '0;
            c_q         <= '0;
            frame_err_q <= 1'b0;
        end else begin
            r_q         <= r_d;
            c_q         <= c_d;
            frame_err_q <= frame_err_d;
        end
    end

    stream_reg #(
        .W (DW + 1)
    ) u_out_reg (
        .clk      (clk),
        .reset    (reset),
        .load_i   (xfer && kept),
        .data_i   ({in_data, kept_last}),
        .ready_i  (out_ready),
        .valid_o  (out_valid),
        .data_o   (out_payload),
        .accept_o (in_ready)
    );

    assign out_data  = out_payload[DW:1];
    assign out_last  = out_payload[0];
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_unpad_crop.sv
// Random-stimulus bench for unpad_crop: two offset configurations share one
// stimulus driver, checked against a position-based reference queue.
module tb_unpad_crop;

    localparam int SZ = 5;
    localparam int PS = 2 * SZ - 1;
    localparam int R1 = 2;
    localparam int C1 = 3;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } exp_t;

    logic        clk, reset, sel;
    logic [31:0] in_data;
    logic        in_valid, in_last, out_ready;

    logic        ir0, ov0, ol0, fe0, ir1, ov1, ol1, fe1;
    logic [31:0] od0, od1;
    logic        in_ready_s, out_valid_s, out_last_s, frame_err_s;
    logic [31:0] out_data_s;

    int   n_chk, n_fail, pos;
    exp_t q[$];

    unpad_crop #(.SIZE(SZ), .DW(32), .ROW_OFF(0), .COL_OFF(0)) dut0 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid && !sel),
        .in_last(in_last), .in_ready(ir0), .out_data(od0), .out_valid(ov0),
        .out_last(ol0), .out_ready(out_ready || sel), .frame_err(fe0)
    );

    unpad_crop #(.SIZE(SZ), .DW(32), .ROW_OFF(R1), .COL_OFF(C1)) dut1 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid && sel),
        .in_last(in_last), .in_ready(ir1), .out_data(od1), .out_valid(ov1),
        .out_last(ol1), .out_ready(out_ready || !sel), .frame_err(fe1)
    );

    assign in_ready_s  = sel ? ir1 : ir0;
    assign out_valid_s = sel ? ov1 : ov0;
    assign out_data_s  = sel ? od1 : od0;
    assign out_last_s  = sel ? ol1 : ol0;
    assign frame_err_s = sel ? fe1 : fe0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (sel=%0d t=%0t)", tag, got, exp, sel, $time);
        end
    endtask

    // One clock of stimulus; entered and left just after a falling edge.
    task automatic step(input bit v, input logic [31:0] d, input bit l, input bit rdy, output bit took);
        bit          ov, ol, out_x, in_x, kept, kl, err_e, exp_v;
        logic [31:0] od;
        int          r, c, ro, co;
        exp_t        e;
        in_valid = v; in_data = d; in_last = l; out_ready = rdy;
        #1;
        ov = out_valid_s; od = out_data_s; ol = out_last_s;
        out_x = ov && rdy;
        in_x  = v && in_ready_s;
        kept = 0; kl = 0; err_e = 0;
        check("in_ready", in_ready_s, !ov || rdy);
        if (out_x) begin
            if (q.size() == 0) check("spurious_out", od, 32'hFFFF_FFFF);
            else begin
                e = q.pop_front();
                check("out_data", od, e.d);
                check("out_last", ol, e.l);
            end
        end
        if (in_x) begin
            ro = sel ? R1 : 0;
            co = sel ? C1 : 0;
            r = pos / PS;
            c = pos % PS;
            kept = (r >= ro) && (r < ro + SZ) && (c >= co) && (c < co + SZ);
            kl = kept && (r == ro + SZ - 1) && (c == co + SZ - 1);
            if (kept) q.push_back('{d, kl});
            err_e = (l != (pos == PS * PS - 1));
            pos = (l || pos == PS * PS - 1) ? 0 : pos + 1;
        end
        @(posedge clk);
        @(negedge clk);
        exp_v = kept ? 1'b1 : (out_x ? 1'b0 : ov);
        check("out_valid", out_valid_s, exp_v);
        if (kept) begin
            check("lat_data", out_data_s, d);
            check("lat_last", out_last_s, kl);
        end else if (ov && !rdy) begin
            check("hold_data", out_data_s, od);
            check("hold_last", out_last_s, ol);
        end
        check("frame_err", frame_err_s, err_e);
        $display("cyc in_v=%0d in_x=%0d d=%0d last=%0d kept=%0d out_x=%0d err=%0d", v, in_x, d, l, kept, out_x, frame_err_s);
        took = in_x;
    endtask

    task automatic send_frame(input int n, input int last_at, input int pv, input int pr);
        int idx, guard;
        bit took;
        idx = 0;
        guard = 0;
        while (idx < n && guard < 5000) begin
            step($urandom_range(99) < pv, idx, idx == last_at, $urandom_range(99) < pr, took);
            if (took) idx++;
            guard++;
        end
        if (idx < n) check("send_timeout", idx, n);
    endtask

    task automatic drain(input int pr);
        int guard;
        bit took;
        guard = 0;
        while (q.size() > 0 && guard < 200) begin
            step(1'b0, 32'd0, 1'b0, $urandom_range(99) < pr, took);
            guard++;
        end
        check("drain_empty", q.size(), 0);
        step(1'b0, 32'd0, 1'b0, 1'b1, took);
    endtask

    task automatic mid_reset();
        reset = 1; in_valid = 0; in_last = 0; out_ready = 0;
        @(posedge clk);
        @(negedge clk);
        check("rst_valid", out_valid_s, 0);
        check("rst_last", out_last_s, 0);
        check("rst_data", out_data_s, 0);
        check("rst_ferr", frame_err_s, 0);
        q.delete();
        pos = 0;
        reset = 0;
        #1;
        check("rst_in_ready", in_ready_s, 1);
        @(negedge clk);
    endtask

    initial begin
        clk = 0; sel = 0; reset = 1; in_valid = 0; in_last = 0; in_data = 0; out_ready = 0;
        n_chk = 0; n_fail = 0; pos = 0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check("init_valid", out_valid_s, 0);
            check("init_last", out_last_s, 0);
            check("init_data", out_data_s, 0);
            check("init_ferr", frame_err_s, 0);
        end
        reset = 0;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check("init_in_ready", in_ready_s, 1);
        end
        @(negedge clk);

        sel = 0; send_frame(81, 80, 100, 100); drain(100);
        sel = 1; send_frame(81, 80, 100, 100); drain(100);
        sel = 0; send_frame(81, 80, 75, 50);   drain(50);
        sel = 1; send_frame(81, 80, 75, 50);   drain(50);

        sel = 0;
        send_frame(51, 50, 100, 100);
        send_frame(81, 80, 100, 100); drain(100);
        send_frame(81, -1, 100, 100);
        send_frame(81, 80, 80, 60);   drain(60);
        send_frame(31, -1, 100, 100);
        mid_reset();
        send_frame(81, 80, 100, 100); drain(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
